// File: rtl/obstacle_mover.sv
// Moves one road obstacle: spawns above the screen in a pseudo-random lane,
// scrolls it down once per frame at the player's speed, pulses passed on exit.
module obstacle_mover #(
    parameter int         START_Y        = -64,
    parameter int         SCREEN_BOTTOM  = 480,
    parameter int         LANE0_X        = 224,
    parameter int         LANE_STEP      = 64,
    parameter int         STEP_PER_SPEED = 2,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic [1:0]         speed,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               visible,
    output logic               passed
);

    localparam logic signed [10:0] Y0     = 11'(START_Y);
    localparam logic signed [10:0] X0     = 11'(LANE0_X);
    localparam logic signed [10:0] XSTEP  = 11'(LANE_STEP);
    localparam logic signed [10:0] BOTTOM = 11'(SCREEN_BOTTOM);

    typedef enum logic [1:0] {S_IDLE, S_SPAWN, S_MOVE, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [7:0]         r_lfsr;
    logic               w_fb;
    logic [1:0]         w_lane;
    logic [2:0]         w_step3;
    logic signed [10:0] r_x, r_y;
    logic signed [10:0] w_inc, w_new_y, w_spawn_x, w_next_x, w_next_y;
    logic               r_visible, r_passed, w_pass;

    // Fibonacci LFSR, taps 8,6,5,4; free-running so lane choice depends on spawn time
    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_lfsr <= LFSR_SEED;
        else         r_lfsr <= {r_lfsr[6:0], w_fb};
    end

    assign w_lane    = (r_lfsr[1:0] == 2'd3) ? 2'd1 : r_lfsr[1:0];
    assign w_spawn_x = X0 + $signed({9'd0, w_lane}) * XSTEP;
    assign w_step3   = 3'(speed * STEP_PER_SPEED);
    assign w_inc     = $signed({8'd0, w_step3});
    assign w_new_y   = r_y + w_inc;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_next_x = r_x;
        w_next_y = r_y;
        w_pass   = 1'b0;
        case (r_state)
            S_IDLE:  if (enable) w_next = S_SPAWN;
            S_SPAWN: begin
                w_next_y = Y0;
                w_next_x = w_spawn_x;
                w_next   = enable ? S_MOVE : S_IDLE;
            end
            S_MOVE: begin
                // abort takes priority over a simultaneous crossing frame
                if (!enable) begin
                    w_next = S_IDLE;
                end else if (startOfFrame) begin
                    w_next_y = w_new_y;
                    if (w_new_y >= BOTTOM) begin
                        w_next = S_DONE;
                        w_pass = 1'b1;
                    end
                end
            end
            S_DONE:  if (!enable) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_x       <= X0;
            r_y       <= Y0;
            r_visible <= 1'b0;
            r_passed  <= 1'b0;
        end else begin
            r_x       <= w_next_x;
            r_y       <= w_next_y;
            r_visible <= (w_next == S_MOVE);
            r_passed  <= w_pass;
        end
    end

    assign topLeftX = r_x;
    assign topLeftY = r_y;
    assign visible  = r_visible;
    assign passed   = r_passed;

endmodule

// File: tb/tb_obstacle_mover.sv
// Self-checking bench for obstacle_mover: directed scenarios plus a randomized
// run compared against a frame-level behavioural model of the obstacle.
module tb_obstacle_mover;

    logic               clk, resetN, startOfFrame, enable;
    logic [1:0]         speed;
    logic signed [10:0] topLeftX, topLeftY;
    logic               visible, passed;

    int tests = 0, fails = 0, pass_seen = 0;

    // behavioural model: where the object is and what it is doing
    int m_y;
    bit m_spawning, m_onscreen, m_finished, m_pass;

    obstacle_mover dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .speed(speed), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .visible(visible), .passed(passed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_y = -64; m_spawning = 0; m_onscreen = 0; m_finished = 0; m_pass = 0;
    endtask

    task automatic model_update(input bit en, input bit sof, input int spd);
        m_pass = 0;
        if (m_onscreen) begin
            if (!en) m_onscreen = 0;
            else if (sof) begin
                m_y = m_y + spd * 2;
                if (m_y >= 480) begin
                    m_onscreen = 0; m_finished = 1; m_pass = 1;
                end
            end
        end else if (m_spawning) begin
            m_spawning = 0;
            m_y = -64;
            if (en) m_onscreen = 1;
        end else if (m_finished) begin
            if (!en) m_finished = 0;
        end else if (en) begin
            m_spawning = 1;
        end
    endtask

    task automatic step(input bit en, input bit sof, input logic [1:0] spd);
        enable = en; startOfFrame = sof; speed = spd;
        @(posedge clk);
        model_update(en, sof, int'(spd));
        #1;
        if (passed === 1'b1) pass_seen++;
    endtask

    task automatic spawn(input logic [1:0] spd);
        step(1, 0, spd);
        step(1, 0, spd);
    endtask

    task automatic frame(input bit en, input logic [1:0] spd);
        step(en, 1, spd);
        step(en, 0, spd);
        step(en, 0, spd);
    endtask

    task automatic go_idle();
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic test_reset();
        resetN = 0; enable = 0; startOfFrame = 0; speed = 0;
        model_reset();
        #23;
        tests++;
        if (topLeftY !== -11'sd64 || topLeftX !== 11'sd224 || visible !== 0 || passed !== 0) begin
            fails++;
            $display("FAIL reset_values: got X=%0d Y=%0d vis=%b pass=%b, want X=224 Y=-64 vis=0 pass=0",
                     topLeftX, topLeftY, visible, passed);
        end
        resetN = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_pass();
        int p0;
        p0 = pass_seen;
        step(1, 0, 3);
        tests++;
        if (visible !== 1'b0) begin fails++; $display("FAIL basic_spawn_vis: got %b want 0", visible); end
        step(1, 0, 3);
        tests++;
        if (visible !== 1'b1 || topLeftY !== -11'sd64) begin
            fails++; $display("FAIL basic_move_entry: got vis=%b Y=%0d want vis=1 Y=-64", visible, topLeftY);
        end
        for (int k = 1; k <= 100; k++) begin
            step(1, 1, 3);
            if (k <= 91) begin
                tests++;
                if (int'(topLeftY) != -64 + 6 * k) begin
                    fails++; $display("FAIL basic_y_frame%0d: got %0d want %0d", k, topLeftY, -64 + 6 * k);
                end
            end
            if (k == 91) begin
                tests++;
                if (passed !== 1'b1 || visible !== 1'b0) begin
                    fails++; $display("FAIL basic_cross: got pass=%b vis=%b want pass=1 vis=0", passed, visible);
                end
            end
            step(1, 0, 3);
            step(1, 0, 3);
        end
        tests++;
        if (pass_seen - p0 != 1 || topLeftY !== 11'sd482 || visible !== 1'b0) begin
            fails++; $display("FAIL basic_final: got pulses=%0d Y=%0d vis=%b want 1 482 0",
                              pass_seen - p0, topLeftY, visible);
        end
        go_idle();
    endtask

    task automatic test_lanes();
        int hit [3];
        hit = '{0, 0, 0};
        for (int i = 0; i < 200; i++) begin
            spawn(0);
            tests++;
            if (topLeftX == 11'sd224) hit[0]++;
            else if (topLeftX == 11'sd288) hit[1]++;
            else if (topLeftX == 11'sd352) hit[2]++;
            else begin fails++; $display("FAIL lane_x: got %0d want one of 224/288/352", topLeftX); end
            step(0, 0, 0);
            repeat ($urandom_range(0, 3)) step(0, 0, 0);
        end
        tests++;
        if (hit[0] == 0 || hit[1] == 0 || hit[2] == 0) begin
            fails++; $display("FAIL lane_coverage: got hits %0d/%0d/%0d want all nonzero", hit[0], hit[1], hit[2]);
        end
        go_idle();
    endtask

    task automatic test_abort();
        int p0;
        p0 = pass_seen;
        spawn(2);
        repeat (10) frame(1, 2);
        tests++;
        if (topLeftY !== -11'sd24) begin fails++; $display("FAIL abort_y_pre: got %0d want -24", topLeftY); end
        step(0, 0, 2);
        tests++;
        if (visible !== 1'b0 || passed !== 1'b0) begin
            fails++; $display("FAIL abort_idle: got vis=%b pass=%b want 0 0", visible, passed);
        end
        step(0, 1, 2);
        step(0, 0, 2);
        tests++;
        if (topLeftY !== -11'sd24 || pass_seen != p0) begin
            fails++; $display("FAIL abort_hold: got Y=%0d pulses=%0d want -24 0", topLeftY, pass_seen - p0);
        end
        go_idle();
    endtask

    task automatic test_zero_speed();
        int p0;
        p0 = pass_seen;
        spawn(0);
        for (int k = 0; k < 50; k++) begin
            frame(1, 0);
            tests++;
            if (topLeftY !== -11'sd64 || visible !== 1'b1) begin
                fails++; $display("FAIL zero_speed_f%0d: got Y=%0d vis=%b want -64 1", k, topLeftY, visible);
            end
        end
        tests++;
        if (pass_seen != p0) begin fails++; $display("FAIL zero_speed_pass: got %0d pulses want 0", pass_seen - p0); end
        go_idle();
    endtask

    task automatic test_collision();
        int p0;
        p0 = pass_seen;
        spawn(3);
        repeat (90) frame(1, 3);
        tests++;
        if (topLeftY !== 11'sd476) begin fails++; $display("FAIL coll_pre_y: got %0d want 476", topLeftY); end
        step(0, 1, 3);
        tests++;
        if (passed !== 1'b0 || visible !== 1'b0 || topLeftY !== 11'sd476) begin
            fails++; $display("FAIL coll_abort_wins: got pass=%b vis=%b Y=%0d want 0 0 476", passed, visible, topLeftY);
        end
        step(0, 0, 3);
        tests++;
        if (pass_seen != p0) begin fails++; $display("FAIL coll_no_pulse: got %0d pulses want 0", pass_seen - p0); end
        go_idle();
    endtask

    task automatic test_hold_enable();
        int p0;
        p0 = pass_seen;
        spawn(3);
        repeat (91) frame(1, 3);
        for (int k = 0; k < 20; k++) begin
            step(1, k[0], 3);
            tests++;
            if (visible !== 1'b0 || passed !== 1'b0) begin
                fails++; $display("FAIL hold_c%0d: got vis=%b pass=%b want 0 0", k, visible, passed);
            end
        end
        tests++;
        if (pass_seen - p0 != 1 || topLeftY !== 11'sd482) begin
            fails++; $display("FAIL hold_single: got pulses=%0d Y=%0d want 1 482", pass_seen - p0, topLeftY);
        end
        go_idle();
    endtask

    task automatic test_reset_mid_move();
        int p0;
        p0 = pass_seen;
        spawn(2);
        repeat (41) frame(1, 2);
        tests++;
        if (topLeftY !== 11'sd100) begin fails++; $display("FAIL rst_pre_y: got %0d want 100", topLeftY); end
        enable = 0; startOfFrame = 0;
        resetN = 0;
        #2;
        model_reset();
        tests++;
        if (topLeftY !== -11'sd64 || topLeftX !== 11'sd224 || visible !== 0 || passed !== 0) begin
            fails++; $display("FAIL rst_mid: got X=%0d Y=%0d vis=%b pass=%b want 224 -64 0 0",
                              topLeftX, topLeftY, visible, passed);
        end
        #2;
        resetN = 1;
        @(posedge clk); #1;
        spawn(2);
        tests++;
        if (topLeftY !== -11'sd64 || visible !== 1'b1 || pass_seen != p0) begin
            fails++; $display("FAIL rst_respawn: got Y=%0d vis=%b pulses=%0d want -64 1 0",
                              topLeftY, visible, pass_seen - p0);
        end
        go_idle();
    endtask

    task automatic test_random();
        bit en, sof;
        logic [1:0] spd;
        int mp = 0, dp0;
        dp0 = pass_seen;
        for (int i = 0; i < 6000; i++) begin
            if (m_onscreen) en = ($urandom_range(0, 511) != 0);
            else            en = ($urandom_range(0, 3) != 0);
            sof = ($urandom_range(0, 2) == 0);
            spd = 2'($urandom_range(0, 3));
            step(en, sof, spd);
            if (m_pass) mp++;
            tests++;
            if (int'(topLeftY) != m_y || visible !== m_onscreen || passed !== m_pass) begin
                fails++; $display("FAIL random_c%0d: got Y=%0d vis=%b pass=%b want %0d %b %b",
                                  i, topLeftY, visible, passed, m_y, m_onscreen, m_pass);
            end
            if (m_onscreen) begin
                tests++;
                if (topLeftX != 11'sd224 && topLeftX != 11'sd288 && topLeftX != 11'sd352) begin
                    fails++; $display("FAIL random_x_c%0d: got %0d want one of 224/288/352", i, topLeftX);
                end
            end
        end
        tests++;
        if (pass_seen - dp0 != mp) begin
            fails++; $display("FAIL random_pulse_count: got %0d want %0d", pass_seen - dp0, mp);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_lanes();
        test_abort();
        test_zero_speed();
        test_collision();
        test_hold_enable();
        test_reset_mid_move();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
